// File: rtl/sap1_alu.sv
// sap1_alu: SAP-1 adder/subtractor with B register, tri-state bus drive and optional flags.
// Define SAP1_ALU_FLAGS_EN to build the carry/zero/overflow flag registers.
module sap1_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] from_BUS,
  input  logic [WIDTH-1:0] accumulator,
  input  logic             enable_load_B,
  input  logic             subtract,
  input  logic             enable_output,
  input  logic             update_flags,
  output tri   [WIDTH-1:0] to_BUS,
  output logic [WIDTH-1:0] B_register,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             overflow_flag
);
  logic [WIDTH-1:0] bop, result;
  logic [WIDTH:0]   sum;
  assign bop    = B_register ^ {WIDTH{subtract}};
  assign sum    = {1'b0, accumulator} + {1'b0, bop} + {{WIDTH{1'b0}}, subtract};
  assign result = sum[WIDTH-1:0];
  assign to_BUS = enable_output ? result : {WIDTH{1'bz}};
  always_ff @(posedge clock or posedge reset)
    if (reset) B_register <= '0;
    else if (!enable_load_B) B_register <= from_BUS;
`ifdef SAP1_ALU_FLAGS_EN
  // flags sample the pre-edge result, so a same-cycle B load never leaks in
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      carry_flag    <= 1'b0;
      zero_flag     <= 1'b0;
      overflow_flag <= 1'b0;
    end else if (update_flags) begin
      carry_flag    <= sum[WIDTH];
      zero_flag     <= result == '0;
      overflow_flag <= (accumulator[WIDTH-1] == bop[WIDTH-1]) && (result[WIDTH-1] != accumulator[WIDTH-1]);
    end
`else
  logic unused_ok;
  assign unused_ok     = ^{update_flags, sum[WIDTH]};
  assign carry_flag    = 1'b0;
  assign zero_flag     = 1'b0;
  assign overflow_flag = 1'b0;
`endif
endmodule

// File: tb/tb_sap1_alu.sv
// tb_sap1_alu: directed scoreboard bench for sap1_alu; flag expectations follow SAP1_ALU_FLAGS_EN.
module tb_sap1_alu;
`ifdef SAP1_ALU_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  typedef struct {
    string      tag;
    logic [7:0] bus;
    logic [2:0] flags;
  } exp_t;
  logic       clock = 1'b0, reset = 1'b1;
  logic [7:0] from_bus = '0, acc = '0;
  logic       load_n = 1'b1, subtract = 1'b0, enable_output = 1'b0, update_flags = 1'b0;
  logic       park = 1'b1;
  logic [7:0] b_reg;
  logic       carry_flag, zero_flag, overflow_flag;
  wire  [7:0] bus;
  exp_t       sb[$];
  int         n_cmp = 0, n_fail = 0;
  // parking driver: the bus reads A5 only if the DUT has released it
  assign bus = park ? 8'hA5 : 8'hzz;
  sap1_alu #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .from_BUS(from_bus), .accumulator(acc),
    .enable_load_B(load_n), .subtract(subtract), .enable_output(enable_output),
    .update_flags(update_flags), .to_BUS(bus), .B_register(b_reg),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .overflow_flag(overflow_flag)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input logic [7:0] b, input logic [2:0] f);
    exp_t e;
    e.tag = tag;
    e.bus = b;
    e.flags = FE ? f : 3'b000;
    sb.push_back(e);
  endtask
  task automatic pop_chk();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_bus"}, bus, e.bus);
      chk({e.tag, "_flags"}, {5'b0, carry_flag, zero_flag, overflow_flag}, {5'b0, e.flags});
    end
  endtask
  task automatic edge1();
    @(posedge clock);
    #1;
  endtask
  initial begin
    #2;
    push("reset", 8'hA5, 3'b000);
    pop_chk();
    chk("reset_b", b_reg, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    acc = 8'hC4;
    from_bus = 8'h3C;
    load_n = 1'b0;
    update_flags = 1'b1;
    edge1();
    chk("load_3c", b_reg, 8'h3C);
    push("pre_reset", 8'hA5, 3'b110);
    edge1();
    pop_chk();
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_b", b_reg, 8'h00);
    push("mid_reset", 8'hA5, 3'b000);
    pop_chk();
    edge1();
    chk("held_reset_b", b_reg, 8'h00);
    push("held_reset", 8'hA5, 3'b000);
    pop_chk();
    @(negedge clock);
    reset = 1'b0;
    edge1();
    chk("resume_b", b_reg, 8'h3C);
    @(negedge clock);
    update_flags = 1'b0;
    acc = 8'h05;
    from_bus = 8'h03;
    park = 1'b0;
    enable_output = 1'b1;
    edge1();
    chk("add_bus_comb", bus, 8'h08);
    @(negedge clock);
    load_n = 1'b1;
    update_flags = 1'b1;
    push("add", 8'h08, 3'b000);
    edge1();
    pop_chk();
    @(negedge clock);
    acc = 8'hFF;
    from_bus = 8'h01;
    load_n = 1'b0;
    update_flags = 1'b0;
    edge1();
    @(negedge clock);
    load_n = 1'b1;
    update_flags = 1'b1;
    push("wrap", 8'h00, 3'b110);
    edge1();
    pop_chk();
    @(negedge clock);
    acc = 8'h03;
    from_bus = 8'h05;
    load_n = 1'b0;
    subtract = 1'b1;
    update_flags = 1'b0;
    edge1();
    @(negedge clock);
    load_n = 1'b1;
    update_flags = 1'b1;
    push("sub_borrow", 8'hFE, 3'b000);
    edge1();
    pop_chk();
    @(negedge clock);
    acc = 8'h80;
    from_bus = 8'h01;
    load_n = 1'b0;
    update_flags = 1'b0;
    edge1();
    @(negedge clock);
    load_n = 1'b1;
    update_flags = 1'b1;
    push("sub_ovf", 8'h7F, 3'b101);
    edge1();
    pop_chk();
    @(negedge clock);
    acc = 8'h00;
    subtract = 1'b0;
    from_bus = 8'h00;
    load_n = 1'b0;
    update_flags = 1'b0;
    edge1();
    @(negedge clock);
    from_bus = 8'h10;
    update_flags = 1'b1;
    push("same_cycle", 8'h10, 3'b010);
    edge1();
    pop_chk();
    @(negedge clock);
    load_n = 1'b1;
    update_flags = 1'b0;
    acc = 8'h22;
    #1;
    chk("comb_follow", bus, 8'h32);
    enable_output = 1'b0;
    park = 1'b1;
    #1;
    chk("release", bus, 8'hA5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #5000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
